prio_encoder_pipe: RTL and testbench
====================================

// Module: prio_encoder_pipe
// PURPOSE
//  Parametrised, pipelined priority encoder: N-bit one-hot/multi-hot vector -> index of winning set bit.
//  Direction selectable: highest-index or lowest-index bit wins; explicit found flag when no bit is set.
//  Two register stages with valid/ready handshake; sustains one vector per clock at N=1024.
//  Drop-in successor for the flat combinational encoder in arbitration/lookup paths.
// PARAMETERS
//  N          1024  input vector width; power of 2, >= GROUP
//  GROUP      32    leaf group width for stage 1; power of 2, divides N
//  MSB_FIRST  1     1: highest set index wins; 0: lowest set index wins
//  W          $clog2(N)  index width (derived, localparam; 10 at default)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   x carries a vector
//  in_ready   out  1   block accepts x this cycle
//  x          in   N   input vector
//  out_valid  out  1   y/found valid
//  out_ready  in   1   consumer accepts y/found this cycle
//  y          out  W   index of winning bit; 0 when found=0
//  found      out  1   1 iff x had at least one set bit
// BEHAVIOUR
//  - Reset: out_valid=0, y=0, found=0, all stage valids=0; in_ready=1 the cycle after rst deasserts.
//    rst mid-operation discards all in-flight vectors; no output for them ever appears.
//  - Transfer on in_valid&in_ready (input) and out_valid&out_ready (output).
//  - Stage 1 (registered): split x into G=N/GROUP groups; per group store any_g and local idx_g ($clog2(GROUP) bits),
//    winner chosen by MSB_FIRST within the group.
//  - Stage 2 (registered, drives outputs): pick winning group (highest g with any_g if MSB_FIRST, else lowest);
//    y = {g, idx_g}; found = |any. No group set -> y=0, found=0 (never X, never stale).
//  - Latency: exactly 2 cycles from input transfer to out_valid when out_ready held 1; throughput 1/cycle.
//  - Backpressure: stage k loads when empty or when its content is leaving this cycle.
//    s2_load = s1_valid & (~out_valid | out_ready); in_ready = ~s1_valid | s2_load.
//    Combinational out_ready -> in_ready path permitted; no bubble on simultaneous drain+fill.
//  - Stalled stage holds y/found/valid stable; outputs never change while out_valid & ~out_ready.
//  - Order preserved; no drop, no duplication. Max 2 vectors in flight.
//  - x ignored when in_valid=0; stage-1 data registers may hold stale values but valids gate all outputs.
//  - All index arithmetic unsigned, width W; no truncation since G*GROUP=N.
// STRUCTURE
//  - prio_enc_pkg.vh: `define-free localparams/function clog2 helper, PRIO_MSB/PRIO_LSB mode constants.
//  - Sub-module prio_enc_leaf #(GROUP, MSB_FIRST): combinational GROUP-bit encoder -> {any, idx};
//    instantiated G times in stage 1, reused once (width G) for group select in stage 2.
//  - Top holds only pipeline registers and handshake logic.
// TESTING (N=1024, GROUP=32 unless noted)
//  - x=1<<1023, out_ready=1 -> y=1023, found=1, out_valid exactly 2 cycles after accept.
//  - x=0 -> y=0, found=0, out_valid=1; x=1 -> y=0, found=1 (distinguished by found).
//  - x=bits{5,700}: MSB_FIRST=1 -> y=700; MSB_FIRST=0 -> y=5; x=bits{31,32} -> 32 / 31 (group boundary).
//  - Back-to-back 8 vectors x=1<<(k*100), out_ready=1 -> y=0,100,..,700 on consecutive cycles, in_ready stays 1.
//  - out_ready=0 for 4 cycles while in_valid=1 -> in_ready drops after 2 accepts, y held stable;
//    release -> remaining results in order, none lost.
//  - rst pulsed 1 cycle with 2 vectors in flight -> out_valid=0 next cycle, no stale result emitted.
//  - Self-check vs reference model on 10k random vectors (sparse and dense), random out_ready, both modes.

Source files
------------

// File: rtl/prio_encoder_pipe_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Mode values select which end of the vector wins.
package prio_encoder_pipe_pkg;

   localparam int PRIO_LSB = 0;
   localparam int PRIO_MSB = 1;

   // A 1-bit vector still needs a 1-bit index port.
   function automatic int idx_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/prio_encoder_pipe_if.sv
// Valid/ready bus of the priority encoder: vector in, index/found out.
// The master side produces vectors and consumes results; the slave is the encoder.
interface prio_encoder_pipe_if #(
   parameter int N = 1024
);

   localparam int W = $clog2(N);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] x;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         found;

   modport master (
      output in_valid, x, out_ready,
      input  in_ready, out_valid, y, found
   );

   modport slave (
      input  in_valid, x, out_ready,
      output in_ready, out_valid, y, found
   );

endinterface

// File: rtl/prio_encoder_pipe_leaf.sv
// Combinational priority encoder over a small vector: reports any-set and the winning index.
// Used both for the per-group leaves and for the final group select.
module prio_encoder_pipe_leaf
   import prio_encoder_pipe_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MSB_FIRST = PRIO_MSB
) (
   input  logic [WIDTH-1:0]             vec,
   output logic                         any,
   output logic [idx_width(WIDTH)-1:0]  idx
);

   localparam int IW = idx_width(WIDTH);

   // Scan toward the favoured end so the last hit seen is the winner; idx stays 0 when nothing is set.
   always_comb begin
      any = |vec;
      idx = '0;
      if (MSB_FIRST == PRIO_MSB) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = IW'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Two-stage pipelined priority encoder with valid/ready handshake.
// Stage 1 registers per-group any/index; stage 2 selects the winning group and drives the outputs.
module prio_encoder_pipe
   import prio_encoder_pipe_pkg::*;
#(
   parameter int N         = 1024,
   parameter int GROUP     = 32,
   parameter int MSB_FIRST = PRIO_MSB
) (
   input  logic                 clk,
   input  logic                 rst,
   prio_encoder_pipe_if.slave   bus
);

   localparam int G  = N / GROUP;
   localparam int LW = idx_width(GROUP);
   localparam int GW = idx_width(G);
   localparam int W  = $clog2(N);

   logic [G-1:0]         leaf_any;
   logic [G-1:0][LW-1:0] leaf_idx;

   logic                 s1_valid_q, s1_valid_d;
   logic [G-1:0]         s1_any_q,   s1_any_d;
   logic [G-1:0][LW-1:0] s1_idx_q,   s1_idx_d;

   logic                 out_valid_q, out_valid_d;
   logic [W-1:0]         y_q,         y_d;
   logic                 found_q,     found_d;

   logic                 grp_any;
   logic [GW-1:0]        grp_idx;
   logic                 s1_load;
   logic                 s2_load;
   logic                 out_free;

   for (genvar g = 0; g < G; g++) begin : g_leaf
      prio_encoder_pipe_leaf #(
         .WIDTH     (GROUP),
         .MSB_FIRST (MSB_FIRST)
      ) u_leaf (
         .vec (bus.x[g*GROUP +: GROUP]),
         .any (leaf_any[g]),
         .idx (leaf_idx[g])
      );
   end

   prio_encoder_pipe_leaf #(
      .WIDTH     (G),
      .MSB_FIRST (MSB_FIRST)
   ) u_group_sel (
      .vec (s1_any_q),
      .any (grp_any),
      .idx (grp_idx)
   );

   // A stage loads when it is empty or its content leaves this cycle; drain and fill may coincide.
   assign out_free = ~out_valid_q | bus.out_ready;
   assign s2_load  = s1_valid_q & out_free;
   assign s1_load  = ~s1_valid_q | s2_load;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_any_d    = s1_any_q;
      s1_idx_d    = s1_idx_q;
      out_valid_d = out_valid_q;
      y_d         = y_q;
      found_d     = found_q;

      if (s1_load) begin
         s1_valid_d = bus.in_valid;
      end
      if (s1_load && bus.in_valid) begin
         s1_any_d = leaf_any;
         s1_idx_d = leaf_idx;
      end

      if (out_free) begin
         out_valid_d = s1_valid_q;
      end
      if (s2_load) begin
         found_d = grp_any;
         y_d     = grp_any ? {grp_idx, s1_idx_q[grp_idx]} : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_any_q    <= '0;
         s1_idx_q    <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         found_q     <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_any_q    <= s1_any_d;
         s1_idx_q    <= s1_idx_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         found_q     <= found_d;
      end
   end

   assign bus.in_ready  = s1_load;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.found     = found_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: an MSB-first and an LSB-first instance share one stimulus stream,
// and a queue-based model checks every delivered result plus stall stability.
module tb_prio_encoder_pipe;

   localparam int N     = 1024;
   localparam int GROUP = 32;
   localparam int W     = 10;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic [N-1:0] x         = '0;

   always #5 clk = ~clk;

   prio_encoder_pipe_if #(.N(N)) bus_msb ();
   prio_encoder_pipe_if #(.N(N)) bus_lsb ();

   assign bus_msb.in_valid  = in_valid;
   assign bus_msb.x         = x;
   assign bus_msb.out_ready = out_ready;
   assign bus_lsb.in_valid  = in_valid;
   assign bus_lsb.x         = x;
   assign bus_lsb.out_ready = out_ready;

   prio_encoder_pipe #(.N(N), .GROUP(GROUP), .MSB_FIRST(1)) u_msb (
      .clk (clk),
      .rst (rst),
      .bus (bus_msb.slave)
   );

   prio_encoder_pipe #(.N(N), .GROUP(GROUP), .MSB_FIRST(0)) u_lsb (
      .clk (clk),
      .rst (rst),
      .bus (bus_lsb.slave)
   );

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] exp_q[$];
   logic [N-1:0] cmp_vec;
   logic         stalled  = 1'b0;
   logic [W-1:0] held_y_m = '0;
   logic [W-1:0] held_y_l = '0;
   logic         held_f   = 1'b0;

   task automatic checkOutput(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Winner is the first set bit met when walking in from the favoured end; 0 if none.
   function automatic int model_index(input logic [N-1:0] v, input bit msb);
      if (msb) begin
         for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
      end else begin
         for (int i = 0; i < N; i++) if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [N-1:0] rand_vec();
      logic [N-1:0] v;
      int           kind;
      v    = '0;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
         v = '0;
      end else if (kind <= 5) begin
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) v[$urandom_range(0, N-1)] = 1'b1;
      end else begin
         for (int w = 0; w < N/32; w++) v[w*32 +: 32] = $urandom();
      end
      return v;
   endfunction

   // Compare process: sampled on the falling edge, inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stalled <= 1'b0;
      end else begin
         if (stalled) begin
            checkOutput("stall_valid", int'(bus_msb.out_valid), 1);
            checkOutput("stall_y_msb", int'(bus_msb.y), int'(held_y_m));
            checkOutput("stall_y_lsb", int'(bus_lsb.y), int'(held_y_l));
            checkOutput("stall_found", int'(bus_msb.found), int'(held_f));
         end
         if (bus_msb.out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_out", 1, 0);
            end else begin
               cmp_vec = exp_q.pop_front();
               checkOutput("model_y_msb", int'(bus_msb.y), model_index(cmp_vec, 1'b1));
               checkOutput("model_y_lsb", int'(bus_lsb.y), model_index(cmp_vec, 1'b0));
               checkOutput("model_found_msb", int'(bus_msb.found), int'(|cmp_vec));
               checkOutput("model_found_lsb", int'(bus_lsb.found), int'(|cmp_vec));
               checkOutput("model_valid_lsb", int'(bus_lsb.out_valid), 1);
            end
         end
         stalled  <= bus_msb.out_valid && !out_ready;
         held_y_m <= bus_msb.y;
         held_y_l <= bus_lsb.y;
         held_f   <= bus_msb.found;
         if (in_valid && bus_msb.in_ready) exp_q.push_back(x);
         checkOutput("in_flight_max2", int'(exp_q.size() <= 2), 1);
      end
   end

   // Present one vector and hold it until accepted; returns aligned just after a rising edge.
   task automatic applyStimulus(input logic [N-1:0] v);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      x        = v;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         acc = bus_msb.in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic waitOutput(input string name, input int ey_m, input int ey_l, input int ef);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus_msb.out_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checkOutput({name, "_seen"}, int'(seen), 1);
      if (seen) begin
         checkOutput({name, "_y_msb"}, int'(bus_msb.y), ey_m);
         checkOutput({name, "_y_lsb"}, int'(bus_lsb.y), ey_l);
         checkOutput({name, "_found"}, int'(bus_msb.found), ef);
         @(posedge clk);
         #1;
      end
   endtask

   logic [N-1:0] v;
   int           bp_idx [4] = '{10, 300, 600, 1000};
   int           got    [4];
   int           got_n;
   int           sent;
   int           stale_cnt;
   bit           acc;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      checkOutput("reset_out_valid", int'(bus_msb.out_valid), 0);
      checkOutput("reset_y", int'(bus_msb.y), 0);
      checkOutput("reset_found", int'(bus_msb.found), 0);
      checkOutput("reset_in_ready", int'(bus_msb.in_ready), 1);
      @(posedge clk);
      #1;

      v = '0; v[5] = 1'b1; v[700] = 1'b1;
      checkOutput("model_pin_msb", model_index(v, 1'b1), 700);
      checkOutput("model_pin_lsb", model_index(v, 1'b0), 5);

      // Top bit, with exact two-cycle latency.
      v = '0; v[1023] = 1'b1;
      in_valid = 1'b1; x = v;
      @(negedge clk);
      checkOutput("lat_accept", int'(bus_msb.in_ready), 1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput("lat_cycle1_valid", int'(bus_msb.out_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("lat_cycle2_valid", int'(bus_msb.out_valid), 1);
      checkOutput("lat_y_msb", int'(bus_msb.y), 1023);
      checkOutput("lat_y_lsb", int'(bus_lsb.y), 1023);
      checkOutput("lat_found", int'(bus_msb.found), 1);
      @(posedge clk); #1;

      applyStimulus('0);
      waitOutput("zero", 0, 0, 0);
      v = '0; v[0] = 1'b1;
      applyStimulus(v);
      waitOutput("one", 0, 0, 1);
      v = '0; v[5] = 1'b1; v[700] = 1'b1;
      applyStimulus(v);
      waitOutput("bits5_700", 700, 5, 1);
      v = '0; v[31] = 1'b1; v[32] = 1'b1;
      applyStimulus(v);
      waitOutput("bits31_32", 32, 31, 1);

      // Back-to-back stream of single-bit vectors.
      for (int c = 0; c < 11; c++) begin
         if (c < 8) begin
            in_valid = 1'b1; x = '0; x[c*100] = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (c < 8) checkOutput("b2b_in_ready", int'(bus_msb.in_ready), 1);
         if (c >= 2 && c < 10) begin
            checkOutput("b2b_valid", int'(bus_msb.out_valid), 1);
            checkOutput("b2b_y_msb", int'(bus_msb.y), (c - 2) * 100);
         end
         @(posedge clk); #1;
      end

      // Backpressure: consumer stalls 4 cycles while the producer keeps offering.
      sent = 0; got_n = 0;
      for (int c = 0; c < 20; c++) begin
         out_ready = (c >= 4);
         in_valid  = (sent < 4);
         x = '0;
         if (sent < 4) x[bp_idx[sent]] = 1'b1;
         @(negedge clk);
         if (c == 2 || c == 3) begin
            checkOutput("bp_in_ready_low", int'(bus_msb.in_ready), 0);
            checkOutput("bp_accepted", sent, 2);
            checkOutput("bp_held_y", int'(bus_msb.y), bp_idx[0]);
         end
         if (in_valid && bus_msb.in_ready) sent++;
         if (bus_msb.out_valid && out_ready) begin
            if (got_n < 4) got[got_n] = int'(bus_msb.y);
            got_n++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checkOutput("bp_count", got_n, 4);
      for (int i = 0; i < 4; i++) checkOutput("bp_order", got[i], bp_idx[i]);

      // Reset with two vectors in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1; x = '0; x[100] = 1'b1;
      @(negedge clk); @(posedge clk); #1;
      x = '0; x[200] = 1'b1;
      @(negedge clk); @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk); @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checkOutput("rst_out_valid", int'(bus_msb.out_valid), 0);
      checkOutput("rst_in_ready", int'(bus_msb.in_ready), 1);
      stale_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (bus_msb.out_valid || bus_lsb.out_valid) stale_cnt++;
      end
      checkOutput("rst_no_stale", stale_cnt, 0);
      @(posedge clk); #1;

      // Random traffic with random backpressure; x held while waiting for acceptance.
      sent = 0; acc = 1'b0; in_valid = 1'b0;
      for (int cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            x        = rand_vec();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_valid && bus_msb.in_ready;
         if (acc) sent++;
         @(posedge clk); #1;
      end
      checkOutput("random_sent", sent, 10000);

      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
